mux_share_arbiter: RTL and testbench
====================================

Name: mux_share_arbiter

Overview:
Two-requester round-robin arbiter that owns the shared 2:1 datapath multiplexer. It drives the mux select bit, grants one requester at a time, and registers the selected data into a one-cycle output beat. A hold limit bounds how long either requester keeps the mux while the other waits.

Parameters:
WIDTH, 8, data width of each requester and of the output
MAX_HOLD, 4, max consecutive beats per grant while the other side is requesting (range 1..15)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
req_a  input  1  requester A wants the mux; held high while it has beats
data_a  input  WIDTH  requester A data (mux input A)
req_b  input  1  requester B wants the mux
data_b  input  WIDTH  requester B data (mux input B)
out_ready  input  1  downstream can take a beat this cycle
grant_a  output  1  A owns the mux (registered)
grant_b  output  1  B owns the mux (registered)
select_bit  output  1  mux select: 0 = A, 1 = B (registered)
out_valid  output  1  one-cycle pulse: out_data holds a transferred beat
out_data  output  WIDTH  registered mux output

Behaviour:
- Clock/reset: one clock (clk); reset_n asynchronous, active-low, clears all state immediately.
- Reset values: state IDLE, grant_a=0, grant_b=0, select_bit=0, out_valid=0, out_data=0, hold_cnt=0, last_served=B (so A wins the first tie).
- States: IDLE, GNT_A, GNT_B. grant_a=1 only in GNT_A, grant_b=1 only in GNT_B; never both.
- IDLE: both req -> grant the side not last_served; one req -> grant that side; none -> stay. select_bit updates in the same edge as the grant; in IDLE it holds its last value.
- Beat: in GNT_X, on a cycle with req_x=1 and out_ready=1, the beat transfers. Next edge: out_data <= data_x, out_valid <= 1, hold_cnt++. Otherwise out_valid <= 0 and out_data holds.
- Latency: data presented while granted with out_ready=1 appears on out_data, with out_valid high, one cycle later.
- Release in GNT_X, evaluated every edge:
  - req_x=0 -> go to GNT_other if req_other, else IDLE. No beat that cycle.
  - Hold limit: hold_cnt reaches MAX_HOLD on this beat and req_other=1 -> switch to GNT_other after the beat.
  - Hold limit with req_other=0: hold_cnt clears, grant is kept.
- On every grant change: hold_cnt <= 0 and last_served <= the side just released. A->B direct switch has no idle bubble, but no beat is taken on the switching edge's new owner until the next cycle.
- out_ready=0: grant is held and hold_cnt frozen (stalled cycles do not count toward MAX_HOLD).
- Simultaneous: req_x drop and hold-limit on the same edge -> the drop rule wins.
- Reset asserted mid-grant or mid-beat: outputs go to reset values immediately; any in-flight beat is lost.

Optional Feature:
MUX_ARB_STATS_EN: when defined, adds output ports beats_a[15:0] and beats_b[15:0]. These are per-requester transferred-beat counters, reset to 0, incremented on each beat, and saturating at 16'hFFFF. When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset, then req_a=1, data_a=8'h3C, out_ready=1 -> grant_a=1 and select_bit=0 after 1 edge; out_data=8'h3C with out_valid=1 on the following edge.
2. From IDLE, req_a=req_b=1 on the same edge -> A granted first. Both kept high with MAX_HOLD=4 -> beats alternate A,A,A,A,B,B,B,B,A... and select_bit toggles accordingly.
3. Grant A, out_ready=0 for 5 cycles with req_b=1 -> grant_a stays 1, out_valid=0, no switch. Then out_ready=1 -> 4 A beats before the switch.
4. Only req_b=1 for 10 beats -> grant_b is held throughout, with 10 out_valid pulses and out_data matching data_b one cycle delayed.
5. req_a drops while req_b=1 -> grant_b=1 on the next edge, grant_a=0 on the same edge, and never both high.
6. Assert reset_n=0 mid-beat, asynchronously between edges -> grant_a, grant_b, out_valid, and out_data all read 0 before the next clk edge. With MUX_ARB_STATS_EN defined, beats_a and beats_b also read 0.

Source files
------------

// File: rtl/mux_share_arbiter.sv
// Two-requester round-robin arbiter driving a shared 2:1 mux with a registered output beat.
// Optional per-requester beat counters are enabled by defining MUX_ARB_STATS_EN.
module mux_share_arbiter #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_b,
    input  logic             out_ready,
    output logic             grant_a,
    output logic             grant_b,
    output logic             select_bit,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [15:0]      beats_a,
    output logic [15:0]      beats_b
`endif
);

    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

    state_t             r_state;
    logic               r_grant_a;
    logic               r_grant_b;
    logic               r_select;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic [3:0]         r_hold_cnt;
    logic               r_last_b;

    logic               w_own_req;
    logic               w_oth_req;
    logic               w_beat;
    logic [3:0]         w_cnt_inc;
    logic               w_limit;
    logic               w_to_other;
    logic               w_to_idle;
    logic [WIDTH-1:0]   w_beat_data;

    always_comb begin
        w_own_req   = (r_state == GNT_B) ? req_b : req_a;
        w_oth_req   = (r_state == GNT_B) ? req_a : req_b;
        w_beat      = (r_state != IDLE) && w_own_req && out_ready;
        w_cnt_inc   = r_hold_cnt + 4'd1;
        w_limit     = (w_cnt_inc == 4'(MAX_HOLD));
        // A dropped request releases without a beat, so it always outranks the hold limit.
        w_to_other  = w_own_req ? (w_beat && w_limit && w_oth_req) : w_oth_req;
        w_to_idle   = !w_own_req && !w_oth_req;
        w_beat_data = (r_state == GNT_B) ? data_b : data_a;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_grant_a   <= 1'b0;
            r_grant_b   <= 1'b0;
            r_select    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_hold_cnt  <= '0;
            r_last_b    <= 1'b1;
        end else begin
            r_out_valid <= w_beat;
            if (w_beat) begin
                r_out_data <= w_beat_data;
            end
            case (r_state)
                IDLE: begin
                    if (req_a && (!req_b || r_last_b)) begin
                        r_state    <= GNT_A;
                        r_grant_a  <= 1'b1;
                        r_select   <= 1'b0;
                        r_hold_cnt <= '0;
                    end else if (req_b) begin
                        r_state    <= GNT_B;
                        r_grant_b  <= 1'b1;
                        r_select   <= 1'b1;
                        r_hold_cnt <= '0;
                    end
                end
                GNT_A, GNT_B: begin
                    if (w_to_other) begin
                        r_state    <= (r_state == GNT_A) ? GNT_B : GNT_A;
                        r_grant_a  <= (r_state == GNT_B);
                        r_grant_b  <= (r_state == GNT_A);
                        r_select   <= (r_state == GNT_A);
                        r_hold_cnt <= '0;
                        r_last_b   <= (r_state == GNT_B);
                    end else if (w_to_idle) begin
                        r_state    <= IDLE;
                        r_grant_a  <= 1'b0;
                        r_grant_b  <= 1'b0;
                        r_hold_cnt <= '0;
                        r_last_b   <= (r_state == GNT_B);
                    end else if (w_beat) begin
                        r_hold_cnt <= w_limit ? '0 : w_cnt_inc;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_grant_a <= 1'b0;
                    r_grant_b <= 1'b0;
                end
            endcase
        end
    end

    assign grant_a    = r_grant_a;
    assign grant_b    = r_grant_b;
    assign select_bit = r_select;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;

`ifdef MUX_ARB_STATS_EN
    logic [15:0] r_beats_a;
    logic [15:0] r_beats_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_beats_a <= '0;
            r_beats_b <= '0;
        end else if (w_beat) begin
            if (r_state == GNT_A && r_beats_a != '1) r_beats_a <= r_beats_a + 16'd1;
            if (r_state == GNT_B && r_beats_b != '1) r_beats_b <= r_beats_b + 16'd1;
        end
    end

    assign beats_a = r_beats_a;
    assign beats_b = r_beats_b;
`endif

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Self-checking bench for mux_share_arbiter: directed vector table, hand sequences,
// and randomized traffic against a behavioural owner/count model.
module tb_mux_share_arbiter;
    localparam int unsigned WIDTH    = 8;
    localparam int unsigned MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             req_a = 1'b0, req_b = 1'b0, out_ready = 1'b0;
    logic [WIDTH-1:0] data_a = '0, data_b = '0;
    logic             grant_a, grant_b, select_bit, out_valid;
    logic [WIDTH-1:0] out_data;
`ifdef MUX_ARB_STATS_EN
    logic [15:0]      beats_a, beats_b;
`endif

    mux_share_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
        .out_ready(out_ready),
        .grant_a(grant_a), .grant_b(grant_b), .select_bit(select_bit),
        .out_valid(out_valid), .out_data(out_data)
`ifdef MUX_ARB_STATS_EN
        , .beats_a(beats_a), .beats_b(beats_b)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_pass = 0, n_total = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: owner 0 = none, 1 = A, 2 = B.
    int unsigned      m_owner, m_cnt, m_last;
    bit               m_sel, m_valid;
    logic [WIDTH-1:0] m_data;
    int unsigned      m_beats_a, m_beats_b;

    task automatic model_reset();
        m_owner = 0; m_cnt = 0; m_last = 2; m_sel = 0; m_valid = 0; m_data = '0;
        m_beats_a = 0; m_beats_b = 0;
    endtask

    task automatic model_step(input bit ra, input bit rb, input bit rdy,
                              input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db);
        bit mine, other;
        m_valid = 0;
        if (m_owner == 0) begin
            if (ra && rb) m_owner = (m_last == 1) ? 2 : 1;
            else if (ra)  m_owner = 1;
            else if (rb)  m_owner = 2;
            if (m_owner != 0) begin m_sel = (m_owner == 2); m_cnt = 0; end
        end else begin
            mine  = (m_owner == 1) ? ra : rb;
            other = (m_owner == 1) ? rb : ra;
            if (!mine) begin
                m_last  = m_owner;
                m_owner = other ? 3 - m_owner : 0;
                m_cnt   = 0;
                if (m_owner != 0) m_sel = (m_owner == 2);
            end else if (rdy) begin
                m_valid = 1;
                m_data  = (m_owner == 1) ? da : db;
                if (m_owner == 1 && m_beats_a < 16'hFFFF) m_beats_a++;
                if (m_owner == 2 && m_beats_b < 16'hFFFF) m_beats_b++;
                m_cnt++;
                if (m_cnt == MAX_HOLD) begin
                    m_cnt = 0;
                    if (other) begin
                        m_last  = m_owner;
                        m_owner = 3 - m_owner;
                        m_sel   = (m_owner == 2);
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; req_a = 0; req_b = 0; out_ready = 0; data_a = '0; data_b = '0;
        @(negedge clk); @(negedge clk);
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic cycle(input bit ra, input bit rb, input bit rdy,
                         input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db);
        @(negedge clk);
        req_a = ra; req_b = rb; out_ready = rdy; data_a = da; data_b = db;
        @(posedge clk);
        model_step(ra, rb, rdy, da, db);
        #1;
        check("grant_a",    32'(grant_a),    32'(m_owner == 1));
        check("grant_b",    32'(grant_b),    32'(m_owner == 2));
        check("select_bit", 32'(select_bit), 32'(m_sel));
        check("out_valid",  32'(out_valid),  32'(m_valid));
        check("out_data",   32'(out_data),   32'(m_data));
`ifdef MUX_ARB_STATS_EN
        check("beats_a", 32'(beats_a), m_beats_a);
        check("beats_b", 32'(beats_b), m_beats_b);
`endif
    endtask

    typedef struct {
        bit ra, rb, rdy;
        logic [WIDTH-1:0] da, db;
        bit ga, gb, sel, v;
        logic [WIDTH-1:0] d;
    } vec_t;

    vec_t vecs[21];
    int unsigned pulses;
    logic [WIDTH-1:0] prev_db;

    initial begin
        vecs[0]  = '{1,1,1,8'hA1,8'hB1, 1,0,0,0,8'h00};
        vecs[1]  = '{1,1,1,8'hA2,8'hB2, 1,0,0,1,8'hA2};
        vecs[2]  = '{1,1,1,8'hA3,8'hB3, 1,0,0,1,8'hA3};
        vecs[3]  = '{1,1,1,8'hA4,8'hB4, 1,0,0,1,8'hA4};
        vecs[4]  = '{1,1,1,8'hA5,8'hB5, 0,1,1,1,8'hA5};
        vecs[5]  = '{1,1,1,8'hA6,8'hB6, 0,1,1,1,8'hB6};
        vecs[6]  = '{1,1,1,8'hA7,8'hB7, 0,1,1,1,8'hB7};
        vecs[7]  = '{1,1,1,8'hA8,8'hB8, 0,1,1,1,8'hB8};
        vecs[8]  = '{1,1,1,8'hA9,8'hB9, 1,0,0,1,8'hB9};
        vecs[9]  = '{1,1,1,8'hAA,8'hBA, 1,0,0,1,8'hAA};
        vecs[10] = '{0,1,1,8'hAB,8'hBB, 0,1,1,0,8'hAA};
        vecs[11] = '{0,1,0,8'hAC,8'hC1, 0,1,1,0,8'hAA};
        vecs[12] = '{0,0,1,8'hAD,8'hC2, 0,0,1,0,8'hAA};
        vecs[13] = '{1,0,1,8'h3C,8'hC3, 1,0,0,0,8'hAA};
        vecs[14] = '{1,0,1,8'h3C,8'hC4, 1,0,0,1,8'h3C};
        vecs[15] = '{1,0,1,8'h40,8'hC5, 1,0,0,1,8'h40};
        vecs[16] = '{1,0,1,8'h41,8'hC6, 1,0,0,1,8'h41};
        vecs[17] = '{1,0,1,8'h42,8'hC7, 1,0,0,1,8'h42};
        vecs[18] = '{1,1,1,8'h43,8'hC8, 1,0,0,1,8'h43};
        vecs[19] = '{1,1,0,8'h44,8'hC9, 1,0,0,0,8'h43};
        vecs[20] = '{0,0,1,8'h45,8'hCA, 0,0,0,0,8'h43};

        do_reset();
        #1;
        check("reset grant_a",   32'(grant_a),    0);
        check("reset grant_b",   32'(grant_b),    0);
        check("reset select",    32'(select_bit), 0);
        check("reset out_valid", 32'(out_valid),  0);
        check("reset out_data",  32'(out_data),   0);

        // Directed vector table from reset
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            req_a = vecs[i].ra; req_b = vecs[i].rb; out_ready = vecs[i].rdy;
            data_a = vecs[i].da; data_b = vecs[i].db;
            @(posedge clk); #1;
            check($sformatf("vec%0d grant_a", i),   32'(grant_a),    32'(vecs[i].ga));
            check($sformatf("vec%0d grant_b", i),   32'(grant_b),    32'(vecs[i].gb));
            check($sformatf("vec%0d select", i),    32'(select_bit), 32'(vecs[i].sel));
            check($sformatf("vec%0d out_valid", i), 32'(out_valid),  32'(vecs[i].v));
            check($sformatf("vec%0d out_data", i),  32'(out_data),   32'(vecs[i].d));
        end

        // Stall with B waiting: stalled cycles must not count toward the hold limit
        do_reset();
        cycle(1, 1, 1, 8'h10, 8'h20);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 1, 0, 8'h11, 8'h21);
            check("stall grant_a", 32'(grant_a), 1);
            check("stall out_valid", 32'(out_valid), 0);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 1, 8'h30 + 8'(i), 8'h21);
            check("post-stall A beat", 32'(out_data), 32'(8'h30 + 8'(i)));
            check("post-stall grant_b", 32'(grant_b), (i == 3) ? 1 : 0);
        end

        // B alone for 10 beats
        do_reset();
        cycle(0, 1, 1, 8'h00, 8'h55);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            prev_db = 8'($urandom);
            cycle(0, 1, 1, 8'h00, prev_db);
            check("solo B grant_b", 32'(grant_b), 1);
            check("solo B data", 32'(out_data), 32'(prev_db));
            if (out_valid) pulses++;
        end
        check("solo B pulses", pulses, 10);

        // Asynchronous reset mid-beat
        do_reset();
        cycle(1, 0, 1, 8'h5A, 8'h00);
        cycle(1, 0, 1, 8'h5B, 8'h00);
        #2 reset_n = 1'b0;
        #1;
        check("async rst grant_a",   32'(grant_a),   0);
        check("async rst grant_b",   32'(grant_b),   0);
        check("async rst out_valid", 32'(out_valid), 0);
        check("async rst out_data",  32'(out_data),  0);
`ifdef MUX_ARB_STATS_EN
        check("async rst beats_a", 32'(beats_a), 0);
        check("async rst beats_b", 32'(beats_b), 0);
`endif
        do_reset();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) != 0, 8'($urandom), 8'($urandom));
            if (grant_a && grant_b) check("never both granted", 1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
